// File: rtl/step_driver_pkg.sv
// Shared types for the step_driver closed-loop counter driver.
// Holds the controller state encoding and the default count width.
package step_driver_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    STEP  = 3'd2,
    CHECK = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/step_driver_dir.sv
// Direction selector for step_driver: picks up (1) or down (0) toward target.
// STEP_DRIVER_WRAP_EN selects shortest modular distance; otherwise plain magnitude compare.
module step_dir_sel
  import step_driver_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] target,
  output logic             up_down
);

`ifdef STEP_DRIVER_WRAP_EN
  localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH - 1);

  logic [WIDTH-1:0] dist;

  // Forward distance wraps naturally; an exact half-turn tie resolves upward.
  always_comb begin
    dist    = target - count_in;
    up_down = (dist <= HALF);
  end
`else
  // Magnitude compare keeps every move on one side of the wrap point.
  always_comb begin
    up_down = (target > count_in);
  end
`endif

endmodule

// File: rtl/step_driver.sv
// Closed-loop step driver: walks an external up/down counter one step at a time
// toward a commanded target and flags an error if the counter fails to follow.
// Optional build macro STEP_DRIVER_WRAP_EN (handled inside step_dir_sel).
module step_driver
  import step_driver_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_value,
  input  logic [WIDTH-1:0] count_in,
  output logic             en,
  output logic             up_down,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] expected;
  logic             dir;
  logic             err_q;
  logic             sel_up;
  logic             accept;
  logic             hit_target;
  logic             follow_ok;

  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v,
                                                input logic             up);
    return up ? (v + WIDTH'(1)) : (v - WIDTH'(1));
  endfunction

  step_dir_sel #(
    .WIDTH(WIDTH)
  ) u_dir_sel (
    .count_in(count_in),
    .target  (target),
    .up_down (sel_up)
  );

  always_comb begin
    accept     = tgt_valid && tgt_ready;
    hit_target = (count_in == target);
    follow_ok  = (count_in == expected);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = hit_target ? IDLE : STEP;
      STEP:    state_nxt = CHECK;
      CHECK: begin
        if (!follow_ok)     state_nxt = ERR;
        else if (hit_target) state_nxt = IDLE;
        else                 state_nxt = STEP;
      end
      ERR:     if (accept) state_nxt = CALC;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: target, latched direction, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      target <= '0;
      dir    <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        target <= tgt_value;
        err_q  <= 1'b0;
      end
      if (state == CALC && !hit_target) dir <= sel_up;
      if (state == CHECK && !follow_ok) err_q <= 1'b1;
    end
  end

  // Expected follow-up value; direction comes from the selector only at CALC,
  // afterwards the latched direction keeps the move monotonic.
  always_ff @(posedge clk) begin
    if (state == CALC)       expected <= step_val(count_in, sel_up);
    else if (state == CHECK) expected <= step_val(count_in, dir);
  end

  // Output logic
  always_comb begin
    tgt_ready = !rst && (state == IDLE || state == ERR);
    en        = (state == STEP);
    busy      = (state == CALC) || (state == STEP) || (state == CHECK);
    done      = ((state == CALC) && hit_target) ||
                ((state == CHECK) && follow_ok && hit_target);
    up_down   = dir;
    err       = err_q;
  end

endmodule

// File: tb/tb_step_driver.sv
// Directed self-checking bench for step_driver, with a behavioural up/down
// counter closing the loop on en/up_down.
module tb_step_driver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tgt_valid;
  logic         tgt_ready;
  logic [W-1:0] tgt_value;
  logic [W-1:0] count_in;
  logic         en;
  logic         up_down;
  logic         busy;
  logic         done;
  logic         err;

  logic [W-1:0] cnt;
  logic [W-1:0] load_val;
  logic         load_en;
  logic         stuck;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Counter under control; stuck freezes it to emulate a broken follower.
  always @(posedge clk) begin
    if (load_en)             cnt <= load_val;
    else if (en && !stuck)   cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
  end

  assign count_in = cnt;

  step_driver #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_value(tgt_value),
    .count_in (count_in),
    .en       (en),
    .up_down  (up_down),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [W-1:0] v);
    load_en  = 1'b1;
    load_val = v;
    tick();
    load_en  = 1'b0;
  endtask

  task automatic run_move(input string tag, input logic [W-1:0] start,
                          input logic [W-1:0] tgt, input int exp_steps,
                          input logic exp_dir, input bit noise);
    int steps, bad, busy_n, cyc, seen;
    preset(start);
    check_eq({tag, "_ready"}, tgt_ready, 1);
    tgt_valid = 1'b1;
    tgt_value = tgt;
    tick();
    tgt_valid = 1'b0;
    steps = 0; bad = 0; busy_n = 0; cyc = 1; seen = 0;
    while (cyc <= 100) begin
      if (noise && cyc < 3) begin
        tgt_valid = 1'b1;
        tgt_value = ~tgt;
      end else begin
        tgt_valid = 1'b0;
      end
      if (busy) busy_n++;
      if (en) begin
        steps++;
        if (up_down !== exp_dir) bad++;
      end
      if (done) begin
        seen = 1;
        break;
      end
      tick();
      cyc++;
    end
    tgt_valid = 1'b0;
    check_eq({tag, "_done_seen"}, seen, 1);
    check_eq({tag, "_latency"}, cyc, 1 + 2 * exp_steps);
    check_eq({tag, "_steps"}, steps, exp_steps);
    check_eq({tag, "_dir_errs"}, bad, 0);
    check_eq({tag, "_busy_cycles"}, busy_n, cyc);
    check_eq({tag, "_final_count"}, count_in, tgt);
    check_eq({tag, "_err"}, err, 0);
    tick();
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
    check_eq({tag, "_idle_ready"}, tgt_ready, 1);
    check_eq({tag, "_idle_en"}, en, 0);
    if (exp_steps > 0) check_eq({tag, "_dir_hold"}, up_down, exp_dir);
  endtask

  initial begin
    int enc, done_n;
    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_value = '0;
    load_en   = 1'b0;
    load_val  = '0;
    stuck     = 1'b0;
    tick();
    tick();
    check_eq("rst_ready", tgt_ready, 0);
    check_eq("rst_en", en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_up_down", up_down, 1);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", tgt_ready, 1);

    run_move("up5", 4'd0, 4'd5, 5, 1'b1, 1'b0);
    run_move("same9", 4'd9, 4'd9, 0, 1'b1, 1'b0);
`ifdef STEP_DRIVER_WRAP_EN
    run_move("wrap14to1", 4'd14, 4'd1, 3, 1'b1, 1'b0);
`else
    run_move("wrap14to1", 4'd14, 4'd1, 13, 1'b0, 1'b0);
`endif
    run_move("tie0to8", 4'd0, 4'd8, 8, 1'b1, 1'b0);
    run_move("down5to2_busy_cmd", 4'd5, 4'd2, 3, 1'b0, 1'b1);

    // Counter that refuses to move
    preset(4'd3);
    stuck     = 1'b1;
    tgt_valid = 1'b1;
    tgt_value = 4'd6;
    tick();
    tgt_valid = 1'b0;
    check_eq("stuck_calc_busy", busy, 1);
    tick();
    check_eq("stuck_step_en", en, 1);
    check_eq("stuck_step_dir", up_down, 1);
    tick();
    check_eq("stuck_check_done", done, 0);
    tick();
    check_eq("stuck_err", err, 1);
    check_eq("stuck_ready", tgt_ready, 1);
    check_eq("stuck_en", en, 0);
    check_eq("stuck_busy", busy, 0);
    tick();
    tick();
    check_eq("stuck_err_sticky", err, 1);
    check_eq("stuck_en_hold", en, 0);
    stuck     = 1'b0;
    tgt_valid = 1'b1;
    tgt_value = 4'd3;
    tick();
    tgt_valid = 1'b0;
    check_eq("recover_err_clear", err, 0);
    check_eq("recover_done", done, 1);
    tick();
    check_eq("recover_ready", tgt_ready, 1);

    // Reset during the third STEP of 0 -> 6
    preset(4'd0);
    tgt_valid = 1'b1;
    tgt_value = 4'd6;
    tick();
    tgt_valid = 1'b0;
    enc = 0;
    for (int i = 0; i < 20; i++) begin
      if (en) enc++;
      if (enc == 3) break;
      tick();
    end
    check_eq("abort_reached_step3", enc, 3);
    rst = 1'b1;
    tick();
    check_eq("abort_rst_en", en, 0);
    check_eq("abort_rst_busy", busy, 0);
    check_eq("abort_rst_ready", tgt_ready, 0);
    check_eq("abort_rst_done", done, 0);
    tick();
    check_eq("abort_rst2_en", en, 0);
    check_eq("abort_rst2_ready", tgt_ready, 0);
    rst = 1'b0;
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (done) done_n++;
      tick();
    end
    check_eq("abort_no_done", done_n, 0);
    check_eq("abort_idle_ready", tgt_ready, 1);
    check_eq("abort_idle_busy", busy, 0);
    check_eq("abort_count", count_in, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
